renode_mem_arbiter: RTL

Shares the single Renode memory bridge channel between `NumPorts` TCDM-style requesters, for example several HWPE master ports in the testbench. Each requester sees a req/gnt/rvalid port. The arbiter serialises accesses round-robin, translates byte enables into Renode access sizes, and forwards exactly one transaction at a time to the downstream request/response channel that feeds the Renode memory model.

---
 rtl/renode_arb_pkg.sv | 57 +++++
 rtl/renode_rr_arbiter.sv | 46 ++++
 rtl/renode_mem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/renode_arb_pkg.sv
// Shared types and byte-enable decode for the Renode memory bridge arbiter.
package renode_arb_pkg;

   localparam int unsigned BeWidth  = 4;
   localparam int unsigned BusWidth = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      RESPOND   = 2'd3
   } arb_state_e;

   // Numbered to match the Renode byte/word/doubleword access actions
   typedef enum logic [1:0] {
      BYTE    = 2'd0,
      WORD16  = 2'd1,
      DWORD32 = 2'd2
   } access_size_e;

   typedef struct packed {
      logic         legal;
      access_size_e size;
      logic [1:0]   offset;
   } be_decode_t;

   function automatic be_decode_t decode_be(input logic [BeWidth-1:0] be);
      be_decode_t d;
      d.legal  = 1'b1;
      d.size   = BYTE;
      d.offset = 2'd0;
      case (be)
         4'b0001: d.offset = 2'd0;
         4'b0010: d.offset = 2'd1;
         4'b0100: d.offset = 2'd2;
         4'b1000: d.offset = 2'd3;
         4'b0011: d.size   = WORD16;
         4'b1100: begin
            d.size   = WORD16;
            d.offset = 2'd2;
         end
         4'b1111: d.size   = DWORD32;
         default: d.legal  = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic [BusWidth-1:0] be_mask(input logic [BeWidth-1:0] be);
      logic [BusWidth-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < BeWidth; b++) begin
         m[b*8 +: 8] = {8{be[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// Round-robin pointer and one-hot grant; the pointer moves to the winner when advance_i is high.
module renode_rr_arbiter
   import renode_arb_pkg::*;
#(
   parameter int unsigned NumPorts = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumPorts-1:0]         req_i,
   input  logic                        advance_i,
   output logic [NumPorts-1:0]         gnt_o,
   output logic [$clog2(NumPorts)-1:0] gnt_idx_o
);

   localparam int unsigned IdxWidth = $clog2(NumPorts);

   logic [IdxWidth-1:0] ptr_q;

   // Search starts at the port after the last granted one
   always_comb begin
      int unsigned idx;
      logic        found;
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned i = 1; i <= NumPorts; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NumPorts) idx = idx - NumPorts;
         if (!found && req_i[IdxWidth'(idx)]) begin
            found                  = 1'b1;
            gnt_o[IdxWidth'(idx)]  = 1'b1;
            gnt_idx_o              = IdxWidth'(idx);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= IdxWidth'(NumPorts - 1);
      end else if (advance_i && (|req_i)) begin
         ptr_q <= gnt_idx_o;
      end
   end

endmodule

// File: rtl/renode_mem_arbiter.sv
// Serialises NumPorts TCDM requesters onto the single Renode memory bridge channel.
// Optional features: RENODE_ARB_TIMEOUT_EN (response watchdog), RENODE_ARB_ASSERT_EN (protocol assertion).
module renode_mem_arbiter
   import renode_arb_pkg::*;
#(
   parameter int unsigned NumPorts      = 4,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NumPorts-1:0]             req_i,
   input  logic [NumPorts*AddrWidth-1:0]   addr_i,
   input  logic [NumPorts-1:0]             we_i,
   input  logic [NumPorts*BeWidth-1:0]     be_i,
   input  logic [NumPorts*DataWidth-1:0]   wdata_i,
   output logic [NumPorts-1:0]             gnt_o,
   output logic [NumPorts-1:0]             rvalid_o,
   output logic [NumPorts*DataWidth-1:0]   rdata_o,
   output logic [NumPorts-1:0]             err_o,
   output logic                            m_req_valid_o,
   input  logic                            m_req_ready_i,
   output logic [AddrWidth-1:0]            m_addr_o,
   output logic                            m_we_o,
   output logic [1:0]                      m_size_o,
   output logic [DataWidth-1:0]            m_wdata_o,
   input  logic                            m_resp_valid_i,
   input  logic [DataWidth-1:0]            m_rdata_i,
   input  logic                            m_err_i,
   output logic                            busy_o
);

   localparam int unsigned IdxWidth = $clog2(NumPorts);

   if (DataWidth != 32) begin : g_bad_data_width
      $error("renode_mem_arbiter: DataWidth must be 32");
   end
   if (NumPorts < 2 || NumPorts > 16) begin : g_bad_num_ports
      $error("renode_mem_arbiter: NumPorts must be in 2..16");
   end
   if (TimeoutCycles < 1) begin : g_bad_timeout
      $error("renode_mem_arbiter: TimeoutCycles must be at least 1");
   end

   arb_state_e            state_q;
   logic [NumPorts-1:0]   rr_gnt;
   logic [IdxWidth-1:0]   rr_idx;
   logic                  advance;
   logic [NumPorts-1:0]   owner_q;
   logic [NumPorts-1:0]   rvalid_q;
   logic [BeWidth-1:0]    be_q;
   logic [1:0]            offset_q;
   logic [BusWidth-1:0]   resp_data_q;
   logic                  resp_err_q;
   logic                  timeout_hit;

   logic [AddrWidth-1:0]  sel_addr;
   logic                  sel_we;
   logic [BeWidth-1:0]    sel_be;
   logic [DataWidth-1:0]  sel_wdata;
   be_decode_t            sel_dec;
   logic [BusWidth-1:0]   rd_aligned;

   assign advance = (state_q == IDLE);

   renode_rr_arbiter #(
      .NumPorts (NumPorts)
   ) u_rr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .advance_i (advance),
      .gnt_o     (rr_gnt),
      .gnt_idx_o (rr_idx)
   );

   // Grant is only offered in IDLE and is suppressed while reset is held
   assign gnt_o = (advance && rst_ni) ? rr_gnt : '0;

   assign sel_addr  = addr_i[rr_idx*AddrWidth +: AddrWidth];
   assign sel_we    = we_i[rr_idx];
   assign sel_be    = be_i[rr_idx*BeWidth +: BeWidth];
   assign sel_wdata = wdata_i[rr_idx*DataWidth +: DataWidth];
   assign sel_dec   = decode_be(sel_be);

   // Move the response back onto its byte lanes and blank lanes outside be
   assign rd_aligned = (m_rdata_i << {offset_q, 3'b000}) & be_mask(be_q);

`ifdef RENODE_ARB_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
   logic [CntWidth-1:0] to_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q <= '0;
      end else if (state_q == ISSUE || state_q == WAIT_RESP) begin
         to_cnt_q <= to_cnt_q + CntWidth'(1);
      end else begin
         to_cnt_q <= '0;
      end
   end

   assign timeout_hit = (to_cnt_q >= CntWidth'(TimeoutCycles - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         rvalid_q      <= '0;
         be_q          <= '0;
         offset_q      <= '0;
         resp_data_q   <= '0;
         resp_err_q    <= 1'b0;
         m_req_valid_o <= 1'b0;
         m_addr_o      <= '0;
         m_we_o        <= 1'b0;
         m_size_o      <= '0;
         m_wdata_o     <= '0;
         busy_o        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_i) begin
                  owner_q  <= rr_gnt;
                  be_q     <= sel_be;
                  offset_q <= sel_dec.offset;
                  busy_o   <= 1'b1;
                  if (sel_dec.legal) begin
                     state_q       <= ISSUE;
                     m_req_valid_o <= 1'b1;
                     m_addr_o      <= (sel_addr & ~AddrWidth'(3)) | AddrWidth'(sel_dec.offset);
                     m_we_o        <= sel_we;
                     m_size_o      <= sel_dec.size;
                     m_wdata_o     <= sel_wdata >> {sel_dec.offset, 3'b000};
                  end else begin
                     state_q     <= RESPOND;
                     rvalid_q    <= rr_gnt;
                     resp_data_q <= '0;
                     resp_err_q  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (m_req_ready_i) begin
                  state_q       <= WAIT_RESP;
                  m_req_valid_o <= 1'b0;
               end else if (timeout_hit) begin
                  state_q       <= RESPOND;
                  m_req_valid_o <= 1'b0;
                  rvalid_q      <= owner_q;
                  resp_data_q   <= '0;
                  resp_err_q    <= 1'b1;
               end
            end
            WAIT_RESP: begin
               if (m_resp_valid_i) begin
                  state_q     <= RESPOND;
                  rvalid_q    <= owner_q;
                  resp_data_q <= rd_aligned;
                  resp_err_q  <= m_err_i;
               end else if (timeout_hit) begin
                  state_q     <= RESPOND;
                  rvalid_q    <= owner_q;
                  resp_data_q <= '0;
                  resp_err_q  <= 1'b1;
               end
            end
            RESPOND: begin
               state_q     <= IDLE;
               rvalid_q    <= '0;
               resp_data_q <= '0;
               resp_err_q  <= 1'b0;
               busy_o      <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

   // Response payload appears only on the owner's lane while rvalid is high
   for (genvar p = 0; p < NumPorts; p++) begin : g_resp
      assign rdata_o[p*DataWidth +: DataWidth] = rvalid_q[p] ? resp_data_q : '0;
      assign err_o[p]                          = rvalid_q[p] & resp_err_q;
   end
   assign rvalid_o = rvalid_q;

`ifdef RENODE_ARB_ASSERT_EN
   resp_outside_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
      m_resp_valid_i |-> (state_q == WAIT_RESP))
      else $error("renode_mem_arbiter: m_resp_valid_i outside WAIT_RESP");
`endif

endmodule
